// File: rtl/pp_uart_pkg.sv
// Shared definitions for the peripheral UART transmitter.
//   - word addresses of the memory-mapped registers
//   - STATUS / CTRL bit positions
//   - transmit FSM state type
//   - default baud divisor (115200 baud at 50 MHz)
package pp_uart_pkg;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_DIV    = 8'h02;
  localparam logic [7:0] ADDR_CTRL   = 8'h03;

  localparam int unsigned ST_FULL_BIT  = 0;
  localparam int unsigned ST_EMPTY_BIT = 1;
  localparam int unsigned ST_BUSY_BIT  = 2;
  localparam int unsigned ST_OVF_BIT   = 3;
  localparam int unsigned ST_COUNT_LSB = 4;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_IRQ_BIT = 1;

  localparam int unsigned DIV_RESET_DEFAULT = 434;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/pp_sync_fifo.sv
// Single-clock FIFO, reusable by TX and RX paths.
//   clk, rst_n : clock, async active-low reset (flushes contents)
//   push, din  : write request and data; ignored when full unless popping
//   pop, dout  : read request; dout shows the head entry (show-ahead)
//   full, empty, count : occupancy flags and entry count
// DEPTH must be a power of two so the pointers wrap naturally.
module pp_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so push-while-full is legal then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pp_uart_tx.sv
// Memory-mapped 8N1 UART transmitter behind the peripheral bridge.
//   clk, rst_n : clock, async active-low reset
//   addr       : word address (DATA/STATUS/DIV/CTRL)
//   wr, data_in: register write strobe and data
//   rd         : read strobe; data_out is registered, valid the next cycle
//   uart_tx    : serial line, idles high, driven from a flop
//   irq        : level interrupt, IRQ enable & FIFO empty & FSM idle
module pp_uart_tx
  import pp_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       ctrl_q;
  logic             ovf_q;

  tx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [DIV_W-1:0] baud_cnt, baud_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             tx_d;
  logic             bit_done;

  logic             wr_data;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      rdata;
  logic             unused_data;

  assign unused_data = ^data_in;
  assign wr_data     = wr && (addr == ADDR_DATA);

  pp_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_data),
    .din   (data_in[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DIV_W'(DIV_RESET);
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          ADDR_DIV:  div_q  <= data_in[DIV_W-1:0];
          ADDR_CTRL: ctrl_q <= data_in[1:0];
          default:   ;
        endcase
      end
      if (wr_data && fifo_full && !fifo_pop)
        ovf_q <= 1'b1;
      else if (wr && (addr == ADDR_STATUS) && data_in[ST_OVF_BIT])
        ovf_q <= 1'b0;
    end
  end

  // Transmit FSM
  assign bit_done = (baud_cnt == period_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt;
    period_d  = period_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_q[CTRL_EN_BIT] && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          period_d = (div_q == '0) ? DIV_W'(1) : div_q;
          state_d  = S_START;
        end
      end
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA: begin
        if (bit_done) begin
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = S_STOP;
          else                 shift_d = shift_q >> 1;
        end
      end
      S_STOP:  if (bit_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Line level is computed from the next state so the flop lines up with it.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    baud_d = (state_q == S_IDLE || state_d != state_q || bit_done) ?
             '0 : baud_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      period_q <= DIV_W'(1);
      uart_tx  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_cnt  <= bit_cnt_d;
      baud_cnt <= baud_d;
      period_q <= period_d;
      uart_tx  <= tx_d;
    end
  end

  // Read path and interrupt
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_STATUS: begin
        rdata[ST_FULL_BIT]         = fifo_full;
        rdata[ST_EMPTY_BIT]        = fifo_empty;
        rdata[ST_BUSY_BIT]         = (state_q != S_IDLE);
        rdata[ST_OVF_BIT]          = ovf_q;
        rdata[ST_COUNT_LSB +: CW]  = fifo_count;
      end
      ADDR_DIV:  rdata[DIV_W-1:0] = div_q;
      ADDR_CTRL: rdata[1:0]       = ctrl_q;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd) data_out <= rdata;
      irq <= ctrl_q[CTRL_IRQ_BIT] & fifo_empty & (state_q == S_IDLE);
    end
  end

endmodule
